bin2bcd_seq: RTL and testbench
==============================

BIN2BCD_SEQ -- requirements
Module: bin2bcd_seq

Interface
REQ-001 Parameter: width, default 8, operand width of the upstream calculator; the binary input is 2*width bits.
REQ-002 Parameter: DIGITS, default 5, number of BCD digits; SHALL satisfy 10^DIGITS > 2^(2*width).
REQ-003 clock_i  input  1  clock; all state changes on the rising edge.
REQ-004 reset_i  input  1  reset, asynchronous, active-low.
REQ-005 start_i  input  1  conversion request; sampled only while ready_o=1.
REQ-006 res_i  input  2*width  binary result from the calculator (res_o of the upstream stage).
REQ-007 ack_i  input  1  consumer acknowledge of the presented result.
REQ-008 ready_o  output  1  high in IDLE only.
REQ-009 valid_o  output  1  high in DONE only; bcd_o and sign_o are valid.
REQ-010 bcd_o  output  4*DIGITS  packed BCD, most significant digit in the top nibble.
REQ-011 sign_o  output  1  result negative; see Configuration.

Function
REQ-012 FSM states: IDLE, SHIFT, DONE, all registered.
REQ-013 IDLE: start_i=1 at an edge captures the operand (res_i, or its magnitude per REQ-025), clears the BCD work register, loads the bit counter with 2*width, and enters SHIFT.
REQ-014 SHIFT: each cycle, every work digit >= 5 gets +3, then {work, operand} shifts left 1; the counter decrements; after the 2*width-th shift the FSM enters DONE.
REQ-015 Latency: the capturing edge is N; valid_o rises after edge N+2*width (16 cycles for width=8).
REQ-016 bcd_o and sign_o are output registers, loaded only on the SHIFT->DONE transition; they hold their value through IDLE and SHIFT until the next load.
REQ-017 DONE: valid_o stays high until ack_i=1 at an edge, then the FSM enters IDLE; ack_i in IDLE or SHIFT is ignored.
REQ-018 start_i is ignored in SHIFT and DONE; no queueing.
REQ-019 Boundary values: res_i=0 gives all-zero digits; res_i=all-ones (65535 for width=8) gives no overflow, guaranteed by REQ-002.
REQ-020 start_i and ack_i high together in DONE: ack_i wins and the FSM goes to IDLE; that start_i is dropped.

Reset
REQ-021 reset_i=0 forces IDLE asynchronously, at any time including mid-SHIFT.
REQ-022 Reset values: ready_o=1, valid_o=0, bcd_o=0, sign_o=0, counter=0, work registers=0.
REQ-023 After reset release, the first start_i is accepted on the next rising edge.

Configuration
REQ-024 Macro BIN2BCD_SIGN_EN selects signed input handling.
REQ-025 Defined: res_i is two's complement; if the MSB is 1, the captured operand is -res_i and sign_o is loaded with 1, otherwise 0.
REQ-026 Not defined: res_i is unsigned and sign_o is constant 0; the sign logic SHALL NOT be synthesised.
REQ-027 Latency is identical in both builds.

Structure
REQ-028 Shared package calc_pkg holds the FSM state typedef (IDLE/SHIFT/DONE), the default width constant (8) and the default DIGITS constant (5).
REQ-029 One sub-module, bcd_digit_adj: 4-bit combinational "add 3 if >= 5", instantiated DIGITS times through a generate loop.
REQ-030 The counter width is $clog2(2*width+1).

Verification
REQ-031 res_i=16'h0015, start_i pulse -> after 16 cycles valid_o=1, bcd_o=20'h00021, sign_o=0; ack_i -> ready_o=1 on the next cycle.
REQ-032 res_i=16'hFFFF, unsigned build -> bcd_o=20'h65535; res_i=16'h0000 -> bcd_o=20'h00000.
REQ-033 res_i=16'hFFFC: with BIN2BCD_SIGN_EN -> sign_o=1, bcd_o=20'h00004; without it -> bcd_o=20'h65532, sign_o=0.
REQ-034 reset_i pulsed low at SHIFT cycle 7 -> immediate IDLE, all outputs at reset values, no valid_o; a following start with 16'h0015 converts correctly.
REQ-035 start_i held high through SHIFT and DONE with ack_i delayed 5 cycles -> exactly one conversion, valid_o held 5 cycles, bcd_o stable; start_i+ack_i together in DONE -> IDLE with no new conversion.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg
// Shared definitions for the calculator datapath slice: the binary-to-BCD
// converter state encoding and the default operand and digit sizes.
// No ports (package).
package calc_pkg;

  // Default operand width of the upstream calculator. Its result is 2*width bits.
  localparam int WIDTH_DEF  = 8;
  // Default number of BCD digits. 10^5 > 2^16, so a 16-bit result always fits.
  localparam int DIGITS_DEF = 5;

  // Converter FSM states. The encoding is fixed so the state register stays
  // compatible with older consumers.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj
// One BCD digit of the double-dabble correction step. A digit of 5 or more
// gets 3 added, so that the following left shift carries correctly into the
// next decade.
// Ports:
//   digit     in   4  current BCD digit
//   adjusted  out  4  digit after correction (purely combinational)
module bcd_digit_adj (
  input  logic [3:0] digit,
  output logic [3:0] adjusted
);

  assign adjusted = (digit >= 4'd5) ? digit + 4'd3 : digit;

endmodule

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq
// Sequential binary-to-BCD converter (shift-and-add-3). It takes one bit per
// cycle, so a conversion takes 2*width cycles. The result is held in output
// registers until the consumer acknowledges it.
//
// Build option: define BIN2BCD_SIGN_EN to treat res_i as two's complement.
// The magnitude is converted and sign_o reports a negative input. Without the
// macro, res_i is unsigned and sign_o is tied to 0.
//
// Ports:
//   clock_i  in   1          clock, rising edge
//   reset_i  in   1          asynchronous active-low reset
//   start_i  in   1          conversion request, sampled only while ready_o=1
//   res_i    in   2*width    binary value to convert
//   ack_i    in   1          consumer acknowledge, sampled only while valid_o=1
//   ready_o  out  1          idle, a new request can be accepted
//   valid_o  out  1          bcd_o/sign_o hold a finished result
//   bcd_o    out  4*DIGITS   packed BCD, most significant digit in the top nibble
//   sign_o   out  1          result was negative (signed build only)
//
// state | meaning
// IDLE  | waiting for start_i; ready_o=1
// SHIFT | one adjust+shift per cycle, 2*width cycles
// DONE  | result presented; valid_o=1 until ack_i
module bin2bcd_seq
  import calc_pkg::*;
#(
  parameter int width  = WIDTH_DEF,
  parameter int DIGITS = DIGITS_DEF
) (
  input  logic                  clock_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic [2*width-1:0]    res_i,
  input  logic                  ack_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [4*DIGITS-1:0]   bcd_o,
  output logic                  sign_o
);

  localparam int NBITS = 2 * width;
  localparam int BCDW  = 4 * DIGITS;
  localparam int CNT_W = $clog2(NBITS + 1);

  state_t             state;
  logic [CNT_W-1:0]   count;
  logic [BCDW-1:0]    work;
  logic [BCDW-1:0]    work_adj;
  logic [NBITS-1:0]   operand;
  logic [NBITS-1:0]   operand_load;

  // Adjusted work digits and the operand shift together as one register.
  // The top bit that leaves the work register is always zero when DIGITS is
  // large enough, so it is simply dropped.
  logic [BCDW+NBITS-1:0] shifted;
  logic [BCDW-1:0]       work_next;
  logic [NBITS-1:0]      operand_next;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit    (work[4*g +: 4]),
      .adjusted (work_adj[4*g +: 4])
    );
  end

  assign shifted      = {work_adj, operand} << 1;
  assign work_next    = shifted[BCDW+NBITS-1:NBITS];
  assign operand_next = shifted[NBITS-1:0];

  wire last_shift = (state == SHIFT) && (count == CNT_W'(1));

`ifdef BIN2BCD_SIGN_EN
  logic sign_cap;

  // Convert the magnitude. -(most negative) wraps to itself, which is still
  // the correct unsigned magnitude.
  assign operand_load = res_i[NBITS-1] ? (~res_i + 1'b1) : res_i;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sign_cap <= 1'b0;
      sign_o   <= 1'b0;
    end else begin
      if (state == IDLE && start_i)
        sign_cap <= res_i[NBITS-1];
      if (last_shift)
        sign_o <= sign_cap;
    end
  end
`else
  assign operand_load = res_i;
  assign sign_o       = 1'b0;
`endif

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state   <= IDLE;
      count   <= '0;
      work    <= '0;
      operand <= '0;
      bcd_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_i) begin
            operand <= operand_load;
            work    <= '0;
            count   <= CNT_W'(NBITS);
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          work    <= work_next;
          operand <= operand_next;
          count   <= count - CNT_W'(1);
          if (last_shift) begin
            bcd_o <= work_next;
            state <= DONE;
          end
        end
        DONE: begin
          if (ack_i)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ready_o = (state == IDLE);
  assign valid_o = (state == DONE);

endmodule

// File: tb/tb_bin2bcd_seq.sv
module tb_bin2bcd_seq;

  localparam int W  = 8;
  localparam int D  = 5;
  localparam int NB = 2 * W;

  logic            clock_i = 1'b0;
  logic            reset_i = 1'b0;
  logic            start_i = 1'b0;
  logic            ack_i   = 1'b0;
  logic [NB-1:0]   res_i   = '0;
  logic            ready_o;
  logic            valid_o;
  logic [4*D-1:0]  bcd_o;
  logic            sign_o;

  bin2bcd_seq #(.width(W), .DIGITS(D)) dut (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .res_i   (res_i),
    .ack_i   (ack_i),
    .ready_o (ready_o),
    .valid_o (valid_o),
    .bcd_o   (bcd_o),
    .sign_o  (sign_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct packed {
    logic [4*D-1:0] bcd;
    logic           sign;
  } exp_t;

  exp_t exp_q[$];
  exp_t last_exp = '0;
  int   checks = 0;
  int   errors = 0;

  // Decimal digits by repeated division, sign by the input's MSB.
  function automatic exp_t ref_model(input logic [NB-1:0] v);
    exp_t        e;
    int unsigned mag;
    mag    = v;
    e.sign = 1'b0;
`ifdef BIN2BCD_SIGN_EN
    if (v[NB-1]) begin
      mag    = (1 << NB) - int'(v);
      e.sign = 1'b1;
    end
`endif
    e.bcd = '0;
    for (int i = 0; i < D; i++) begin
      e.bcd[4*i +: 4] = 4'(mag % 10);
      mag = mag / 10;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: pop one expectation per rising valid_o, then watch it stay put.
  logic prev_valid = 1'b0;
  exp_t cur_exp    = '0;
  always @(negedge clock_i) begin
    if (!reset_i) begin
      prev_valid = 1'b0;
    end else begin
      if (valid_o && !prev_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid actual=1 required=0 bcd=%0h at %0t", bcd_o, $time);
        end else begin
          cur_exp = exp_q.pop_front();
          check("bcd", 32'(bcd_o), 32'(cur_exp.bcd));
          check("sign", 32'(sign_o), 32'(cur_exp.sign));
        end
      end else if (valid_o && prev_valid) begin
        check("bcd_stable", 32'({bcd_o, sign_o}), 32'(cur_exp));
      end
      prev_valid = valid_o;
    end
  end

  task automatic convert(input logic [NB-1:0] v, input int ack_delay, input bit hold_start);
    exp_t e;
    int   k;
    e = ref_model(v);
    @(posedge clock_i); #1;
    check("ready_idle", 32'(ready_o), 32'd1);
    res_i   = v;
    start_i = 1'b1;
    exp_q.push_back(e);
    @(posedge clock_i); #1;
    start_i = hold_start;
    res_i   = NB'($urandom);
    check("ready_shift", 32'(ready_o), 32'd0);
    k = 0;
    while (!valid_o && k < 40) begin
      @(posedge clock_i); #1;
      k++;
      if (k == 8)
        check("bcd_held_in_shift", 32'(bcd_o), 32'(last_exp.bcd));
    end
    check("latency", 32'(k), 32'(NB));
    repeat (ack_delay) begin
      @(posedge clock_i); #1;
      check("valid_held", 32'(valid_o), 32'd1);
    end
    ack_i = 1'b1;
    @(posedge clock_i); #1;
    ack_i   = 1'b0;
    start_i = 1'b0;
    check("ready_after_ack", 32'(ready_o), 32'd1);
    check("valid_after_ack", 32'(valid_o), 32'd0);
    last_exp = e;
    if (hold_start) begin
      repeat (20) @(posedge clock_i);
      #1;
      check("no_second_conv", 32'({ready_o, valid_o}), 32'b10);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    check("rst_ready", 32'(ready_o), 32'd1);
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_bcd", 32'(bcd_o), 32'd0);
    check("rst_sign", 32'(sign_o), 32'd0);
    reset_i = 1'b1;

    convert(16'h0015, 0, 1'b0);
    convert(16'hFFFF, 1, 1'b0);
    convert(16'h0000, 0, 1'b0);
    convert(16'hFFFC, 2, 1'b0);
    convert(16'h8000, 0, 1'b0);
    convert(16'h0001, 0, 1'b0);
    convert(16'h270F, 0, 1'b0);
    // start held through SHIFT/DONE, ack late, then start+ack together
    convert(16'h0015, 5, 1'b1);

    // Reset in the middle of a conversion.
    @(posedge clock_i); #1;
    res_i   = 16'h1234;
    start_i = 1'b1;
    @(posedge clock_i); #1;
    start_i = 1'b0;
    repeat (7) @(posedge clock_i);
    #1;
    reset_i = 1'b0;
    #1;
    check("midrst_ready", 32'(ready_o), 32'd1);
    check("midrst_valid", 32'(valid_o), 32'd0);
    check("midrst_bcd", 32'(bcd_o), 32'd0);
    check("midrst_sign", 32'(sign_o), 32'd0);
    last_exp = '0;
    #2;
    reset_i = 1'b1;
    convert(16'h0015, 0, 1'b0);

    for (int i = 0; i < 25; i++)
      convert(NB'($urandom), int'($urandom_range(0, 3)), 1'b0);

    repeat (5) @(posedge clock_i);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
